return_addr_stack: RTL and testbench
====================================

# return_addr_stack

Return-address stack (RAS) for the frontend; sits directly downstream of the instruction pre-decoder and consumes its call/return classification. On a predecoded call it pushes the link address (inst_pc + 4); on a predecoded return it pops and exposes the top-of-stack as the predicted jalr target for the next-PC selector. It is a circular buffer with a saturating occupancy counter, a backend flush, and a single-cycle underflow indication.

## Interface
- ADDR_WIDTH, 32, width of PCs and stored return addresses
- RAS_DEPTH, 8, number of entries; power of two, ≥2; pointer width PTR_W = log2(RAS_DEPTH)
- clk  input  1  core clock, all state on rising edge
- rst_n  input  1  reset, asynchronous, active-low
- pdec_valid  input  1  predecoded instruction accepted by fetch this cycle; qualifies call/ret
- pdec_call  input  1  predecoded call (jal with rd = x1/x5)
- pdec_ret  input  1  predecoded return (jalr, rs1 = x1/x5, rd ≠ x1/x5)
- inst_pc  input  ADDR_WIDTH  PC of the predecoded instruction
- ras_flush  input  1  backend redirect; empties stack
- ras_top  output  ADDR_WIDTH  current top-of-stack address; 0 when empty
- ras_top_valid  output  1  stack non-empty
- ras_full  output  1  count == RAS_DEPTH
- ras_count  output  PTR_W+1  occupancy, 0..RAS_DEPTH
- ras_underflow  output  1  registered one-cycle pulse: pop attempted on empty stack
- ras_overflow  output  1  registered one-cycle pulse: push attempted while full

## Operation
- State: entry array mem[RAS_DEPTH], top pointer tos (PTR_W), count (PTR_W+1).
- push = pdec_valid & pdec_call; pop = pdec_valid & pdec_ret.
- Link address = inst_pc + 4, modulo 2^ADDR_WIDTH (carry discarded).
- Push only: mem[tos+1] <= link; tos <= tos+1 (mod RAS_DEPTH); count <= count+1, saturating at RAS_DEPTH (see Configuration for full case).
- Pop only, count > 0: tos <= tos-1 (mod RAS_DEPTH); count <= count-1; entry contents unchanged.
- Pop only, count == 0: no state change; ras_underflow = 1 next cycle.
- Push and pop together: count > 0 → mem[tos] <= link, tos and count unchanged; count == 0 → treated as push only, no underflow.
- ras_flush: count <= 0, tos <= 0; overrides push/pop in the same cycle; entry array not cleared; underflow/overflow pulses suppressed.
- pdec_call/pdec_ret with pdec_valid = 0 are ignored.
- ras_top = (count != 0) ? mem[tos] : 0; ras_top_valid = (count != 0); ras_full = (count == RAS_DEPTH).

## Timing
- Reset (async assert, sync release): tos = 0, count = 0, mem all 0; ras_top = 0, ras_top_valid = 0, ras_full = 0, ras_count = 0, ras_underflow = 0, ras_overflow = 0.
- ras_top, ras_top_valid, ras_full, ras_count are combinational from registered state only; no input-to-output combinational path.
- Return prediction: ras_top is sampled by next-PC logic in the same cycle pdec_ret is high; the pop takes effect at that rising edge, and the new top is visible the following cycle.
- Push latency: pushed link appears on ras_top one cycle after the push edge.
- ras_underflow / ras_overflow: high exactly one cycle after the offending edge, low otherwise.
- Back-to-back push/pop every cycle supported, no bubbles.

## Configuration
- RAS_OVERFLOW_WRAP_EN defined: push while full overwrites the oldest entry (circular wrap); tos advances, count stays RAS_DEPTH; ras_overflow pulses.
- RAS_OVERFLOW_WRAP_EN undefined: push while full is dropped; tos, count, mem unchanged; ras_overflow pulses. Simultaneous push+pop while full is still a top replacement in both builds.

## Test plan
- Reset, then push with inst_pc = 0x100 → next cycle ras_top = 0x104, ras_top_valid = 1, ras_count = 1.
- Push 0x100, 0x200, 0x300; pop three times → ras_top sequence 0x304, 0x204, 0x104, then ras_top_valid = 0, ras_top = 0; fourth pop → ras_underflow pulses one cycle, count stays 0.
- RAS_DEPTH = 8, push 9 calls with PC 0x10·k (k=1..9): with RAS_OVERFLOW_WRAP_EN, 8 pops return 0x94 down to 0x24; without it, 8 pops return 0x84 down to 0x14; ras_overflow pulses once in both.
- Count = 2 (top 0x204), assert push and pop together with inst_pc = 0x500 → ras_top = 0x504, ras_count = 2; a further pop exposes the original bottom entry.
- Count = 5, assert ras_flush together with push → next cycle ras_count = 0, ras_top_valid = 0, no overflow/underflow pulse.
- Push with inst_pc = 0xFFFFFFFC → ras_top = 0x00000000 with ras_top_valid = 1; assert rst_n low mid-sequence → all outputs at reset values immediately.

Source files
------------

// File: rtl/return_addr_stack.sv
// ---------------------------------------------------------------------------
// return_addr_stack
//   Return-address stack for the fetch frontend. A predecoded call pushes its
//   link address (inst_pc + 4). A predecoded return pops the stack, and the
//   current top-of-stack is offered as the predicted jalr target. The stack is
//   a circular buffer with a saturating occupancy counter. A backend flush
//   empties it, and one-cycle pulses flag underflow and overflow.
//
//   Optional feature macro: RAS_OVERFLOW_WRAP_EN
//     defined   : a push while full overwrites the oldest entry (circular wrap)
//     undefined : a push while full is dropped (default build)
//
// Ports
//   clk, rst_n        clock; asynchronous active-low reset
//   pdec_valid        qualifies pdec_call / pdec_ret
//   pdec_call         predecoded call  -> push inst_pc + 4
//   pdec_ret          predecoded return -> pop
//   inst_pc           PC of the predecoded instruction
//   ras_flush         backend redirect; empties the stack
//   ras_top           top-of-stack address, 0 when empty
//   ras_top_valid     stack non-empty
//   ras_full          occupancy == RAS_DEPTH
//   ras_count         occupancy 0..RAS_DEPTH
//   ras_underflow     registered pulse: pop attempted on an empty stack
//   ras_overflow      registered pulse: push attempted while full
// ---------------------------------------------------------------------------
module return_addr_stack #(
  parameter  int ADDR_WIDTH = 32,
  parameter  int RAS_DEPTH  = 8,
  localparam int PTR_W      = $clog2(RAS_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  pdec_valid,
  input  logic                  pdec_call,
  input  logic                  pdec_ret,
  input  logic [ADDR_WIDTH-1:0] inst_pc,
  input  logic                  ras_flush,
  output logic [ADDR_WIDTH-1:0] ras_top,
  output logic                  ras_top_valid,
  output logic                  ras_full,
  output logic [PTR_W:0]        ras_count,
  output logic                  ras_underflow,
  output logic                  ras_overflow
);

  localparam logic [PTR_W:0] DEPTH_CNT = (PTR_W+1)'(RAS_DEPTH);

  logic [ADDR_WIDTH-1:0] mem_reg [RAS_DEPTH];
  logic [PTR_W-1:0]      tos_reg, tos_next;
  logic [PTR_W:0]        count_reg, count_next;
  logic                  underflow_reg, underflow_next;
  logic                  overflow_reg, overflow_next;

  logic                  push, pop, empty, full;
  logic [ADDR_WIDTH-1:0] link;
  logic                  wr_en;
  logic [PTR_W-1:0]      wr_ptr;
  logic [RAS_DEPTH-1:0]  entry_we;

  assign push  = pdec_valid & pdec_call;
  assign pop   = pdec_valid & pdec_ret;
  assign empty = (count_reg == '0);
  assign full  = (count_reg == DEPTH_CNT);
  // Carry out of the top bit is discarded: the link wraps modulo 2^ADDR_WIDTH.
  assign link  = inst_pc + ADDR_WIDTH'(4);

  // Next-state selection. The flush wins over everything else and also
  // suppresses the error pulses.
  always_comb begin
    tos_next       = tos_reg;
    count_next     = count_reg;
    wr_en          = 1'b0;
    wr_ptr         = tos_reg;
    underflow_next = 1'b0;
    overflow_next  = 1'b0;
    if (ras_flush) begin
      tos_next   = '0;
      count_next = '0;
    end else if (push && pop && !empty) begin
      // Call and return in the same cycle replace the top entry in place.
      // This also applies while the stack is full.
      wr_en  = 1'b1;
      wr_ptr = tos_reg;
    end else if (push) begin
      // This branch also covers push+pop on an empty stack.
      if (!full) begin
        wr_en      = 1'b1;
        wr_ptr     = tos_reg + PTR_W'(1);
        tos_next   = tos_reg + PTR_W'(1);
        count_next = count_reg + (PTR_W+1)'(1);
      end else begin
        overflow_next = 1'b1;
`ifdef RAS_OVERFLOW_WRAP_EN
        // tos+1 is the oldest slot when full, so it is the one overwritten.
        wr_en    = 1'b1;
        wr_ptr   = tos_reg + PTR_W'(1);
        tos_next = tos_reg + PTR_W'(1);
`endif
      end
    end else if (pop) begin
      if (!empty) begin
        tos_next   = tos_reg - PTR_W'(1);
        count_next = count_reg - (PTR_W+1)'(1);
      end else begin
        underflow_next = 1'b1;
      end
    end
  end

  // One-hot write enable per entry.
  genvar gi;
  generate
    for (gi = 0; gi < RAS_DEPTH; gi++) begin : g_we
      assign entry_we[gi] = wr_en && (wr_ptr == PTR_W'(gi));
    end
  endgenerate

  // The entry array is cleared on reset, so it is built from flops rather
  // than block RAM. The top entry is also read combinationally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RAS_DEPTH; i++) mem_reg[i] <= '0;
    end else begin
      for (int i = 0; i < RAS_DEPTH; i++) begin
        if (entry_we[i]) mem_reg[i] <= link;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tos_reg       <= '0;
      count_reg     <= '0;
      underflow_reg <= 1'b0;
      overflow_reg  <= 1'b0;
    end else begin
      tos_reg       <= tos_next;
      count_reg     <= count_next;
      underflow_reg <= underflow_next;
      overflow_reg  <= overflow_next;
    end
  end

  // Outputs depend only on registered state.
  assign ras_top       = empty ? '0 : mem_reg[tos_reg];
  assign ras_top_valid = !empty;
  assign ras_full      = full;
  assign ras_count     = count_reg;
  assign ras_underflow = underflow_reg;
  assign ras_overflow  = overflow_reg;

endmodule

// File: tb/tb_return_addr_stack.sv
module tb_return_addr_stack;

  logic        clk;
  logic        rst_n;
  logic        pdec_valid, pdec_call, pdec_ret, ras_flush;
  logic [31:0] inst_pc;
  logic [31:0] ras_top;
  logic        ras_top_valid, ras_full, ras_underflow, ras_overflow;
  logic [3:0]  ras_count;

  return_addr_stack #(.ADDR_WIDTH(32), .RAS_DEPTH(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .pdec_valid(pdec_valid), .pdec_call(pdec_call), .pdec_ret(pdec_ret),
    .inst_pc(inst_pc), .ras_flush(ras_flush),
    .ras_top(ras_top), .ras_top_valid(ras_top_valid), .ras_full(ras_full),
    .ras_count(ras_count), .ras_underflow(ras_underflow), .ras_overflow(ras_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    string       name;
    logic [31:0] top;
    logic        tv;
    logic [3:0]  cnt;
    logic        full;
    logic        uf;
    logic        of;
  } exp_t;

  exp_t q[$];
  int   cyc_cnt = 0;
  int   checks  = 0;
  int   errors  = 0;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  task automatic compare(input exp_t e);
    checks++;
    if (ras_top !== e.top || ras_top_valid !== e.tv || ras_count !== e.cnt ||
        ras_full !== e.full || ras_underflow !== e.uf || ras_overflow !== e.of) begin
      errors++;
      $display("FAIL %s: got top=%h tv=%b cnt=%0d full=%b uf=%b of=%b, expected top=%h tv=%b cnt=%0d full=%b uf=%b of=%b",
               e.name, ras_top, ras_top_valid, ras_count, ras_full, ras_underflow, ras_overflow,
               e.top, e.tv, e.cnt, e.full, e.uf, e.of);
    end else begin
      $display("ok   %s: top=%h tv=%b cnt=%0d uf=%b of=%b",
               e.name, ras_top, ras_top_valid, ras_count, ras_underflow, ras_overflow);
    end
  endtask

  // Monitor: compare each expectation on the negedge after its launch edge.
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc <= cyc_cnt) begin
      exp_t e;
      e = q.pop_front();
      if (e.cyc < cyc_cnt) begin
        checks++;
        errors++;
        $display("FAIL %s: stale expectation cyc=%0d now=%0d", e.name, e.cyc, cyc_cnt);
      end else begin
        compare(e);
      end
    end
  end

  // Drive one cycle of stimulus and queue the state expected after its edge.
  // This task is called at posedge+1.
  task automatic step(input logic v, input logic c, input logic r, input logic [31:0] pc,
                      input logic f, input string name, input logic [31:0] top,
                      input logic tv, input int cnt, input logic uf, input logic of);
    exp_t e;
    pdec_valid = v; pdec_call = c; pdec_ret = r; inst_pc = pc; ras_flush = f;
    e.cyc  = cyc_cnt + 1;
    e.name = name;
    e.top  = top;
    e.tv   = tv;
    e.cnt  = 4'(cnt);
    e.full = (cnt == 8);
    e.uf   = uf;
    e.of   = of;
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] pc, input string name, input logic [31:0] top, input int cnt, input logic of);
    step(1, 1, 0, pc, 0, name, top, 1'b1, cnt, 1'b0, of);
  endtask

  task automatic pop(input string name, input logic [31:0] top, input int cnt, input logic uf);
    step(1, 0, 1, 32'h0, 0, name, top, cnt != 0, cnt, uf, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] base;
    rst_n = 1'b0; pdec_valid = 0; pdec_call = 0; pdec_ret = 0; ras_flush = 0; inst_pc = '0;
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    step(0, 0, 0, 32'h0, 0, "reset_idle", 32'h0, 0, 0, 0, 0);

    // Single push, then pop back to empty.
    push(32'h100, "push1", 32'h104, 1, 0);
    pop("pop1", 32'h0, 0, 0);

    // A call or return without pdec_valid is ignored.
    step(0, 1, 0, 32'h700, 0, "invalid_call", 32'h0, 0, 0, 0, 0);

    // Push three entries, pop three, then pop on empty.
    push(32'h100, "p3_a", 32'h104, 1, 0);
    push(32'h200, "p3_b", 32'h204, 2, 0);
    push(32'h300, "p3_c", 32'h304, 3, 0);
    step(0, 0, 1, 32'h0, 0, "invalid_ret", 32'h304, 1, 3, 0, 0);
    pop("pop3_a", 32'h204, 2, 0);
    pop("pop3_b", 32'h104, 1, 0);
    pop("pop3_c", 32'h0, 0, 0);
    pop("underflow", 32'h0, 0, 1);
    step(0, 0, 0, 32'h0, 0, "underflow_clear", 32'h0, 0, 0, 0, 0);

    // Push 9 calls into an 8-entry stack.
`ifdef RAS_OVERFLOW_WRAP_EN
    base = 32'h94;
`else
    base = 32'h84;
`endif
    for (int k = 1; k <= 9; k++) begin
      if (k < 9) push(32'h10 * k, $sformatf("fill_%0d", k), 32'h10 * k + 4, k, 0);
      else       push(32'h90, "overflow", base, 8, 1);
    end
    for (int j = 1; j <= 8; j++)
      pop($sformatf("drain_%0d", j), (j == 8) ? 32'h0 : base - 32'h10 * j, 8 - j, 0);

    // Push and pop together replace the top entry.
    push(32'h100, "rep_a", 32'h104, 1, 0);
    push(32'h200, "rep_b", 32'h204, 2, 0);
    step(1, 1, 1, 32'h500, 0, "replace", 32'h504, 1, 2, 0, 0);
    pop("rep_pop1", 32'h104, 1, 0);
    pop("rep_pop2", 32'h0, 0, 0);

    // Push and pop together on an empty stack act as a push only.
    step(1, 1, 1, 32'h40, 0, "pushpop_empty", 32'h44, 1, 1, 0, 0);
    pop("pushpop_empty_pop", 32'h0, 0, 0);

    // A flush overrides a push in the same cycle.
    for (int k = 1; k <= 5; k++) push(32'h100 * k, $sformatf("fl_%0d", k), 32'h100 * k + 4, k, 0);
    step(1, 1, 0, 32'h600, 1, "flush_push", 32'h0, 0, 0, 0, 0);
    step(1, 0, 1, 32'h0, 1, "flush_pop_empty", 32'h0, 0, 0, 0, 0);
    step(0, 0, 0, 32'h0, 0, "flush_idle", 32'h0, 0, 0, 0, 0);

    // The link address wraps at 2^32.
    push(32'hFFFF_FFFC, "pc_wrap", 32'h0, 1, 0);
    push(32'h10, "pre_reset", 32'h14, 2, 0);
    pdec_valid = 0; pdec_call = 0;

    // Asynchronous reset mid-cycle: outputs return to reset values at once.
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    begin
      exp_t e;
      e.cyc = cyc_cnt; e.name = "async_reset"; e.top = 32'h0; e.tv = 0;
      e.cnt = 4'd0; e.full = 0; e.uf = 0; e.of = 0;
      compare(e);
    end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    step(0, 0, 0, 32'h0, 0, "post_reset", 32'h0, 0, 0, 0, 0);
    pop("post_reset_uf", 32'h0, 0, 1);
    step(0, 0, 0, 32'h0, 0, "final_idle", 32'h0, 0, 0, 0, 0);

    repeat (2) @(negedge clk);
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expectations left unchecked, expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
